// File: rtl/ad9361_capture_ctrl_if.sv
// AXI-stream style handshake bundle used for both the serializer input
// and the packet output of ad9361_capture_ctrl.
interface ad9361_capture_ctrl_if #(
   parameter int DATA_WIDTH = 96
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ad9361_capture_ctrl.sv
// Arm/trigger/delay capture sequencer forwarding N beats as one packet.
// Define CAPTURE_STALL_CNT_EN to build the saturating stall counter.
module ad9361_capture_ctrl #(
   parameter int DATA_WIDTH  = 96,
   parameter int LEN_WIDTH   = 16,
   parameter int DELAY_WIDTH = 16,
   parameter int STALL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LEN_WIDTH-1:0]   cfg_length,
   input  logic [DELAY_WIDTH-1:0] cfg_delay,
   input  logic                   cfg_continuous,
   input  logic                   arm,
   input  logic                   abort,
   input  logic                   trigger,
   ad9361_capture_ctrl_if.slave   s_axis,
   ad9361_capture_ctrl_if.master  m_axis,
   output logic                   busy,
   output logic                   done,
   output logic [STALL_WIDTH-1:0] stall_cnt
);
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_DRAIN} state_e;

   localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = 1;
   localparam logic [DELAY_WIDTH-1:0] DELAY_ONE = 1;

   state_e                 state_q, state_d;
   logic [LEN_WIDTH-1:0]   len_cfg_q, len_cfg_d;
   logic [DELAY_WIDTH-1:0] delay_cfg_q, delay_cfg_d;
   logic                   cont_q, cont_d;
   logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
   logic [DELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_last_q, out_last_d;
   logic                   aborted_q, aborted_d;
   logic                   s_ready;
   logic                   m_hs;

   assign m_hs = out_valid_q & m_axis.tready;

   always_comb begin
      state_d     = state_q;
      len_cfg_d   = len_cfg_q;
      delay_cfg_d = delay_cfg_q;
      cont_d      = cont_q;
      beat_cnt_d  = beat_cnt_q;
      delay_cnt_d = delay_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      aborted_d   = aborted_q;
      s_ready     = 1'b0;
      done        = 1'b0;

      if (m_hs) out_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            s_ready = 1'b1;
            if (arm && !abort && cfg_length != '0) begin
               len_cfg_d   = cfg_length;
               delay_cfg_d = cfg_delay;
               cont_d      = cfg_continuous;
               state_d     = S_ARMED;
            end
         end
         S_ARMED: begin
            s_ready = 1'b1;
            if (abort) begin
               cont_d  = 1'b0;
               state_d = S_IDLE;
            end else if (trigger) begin
               beat_cnt_d  = len_cfg_q;
               delay_cnt_d = delay_cfg_q;
               state_d     = (delay_cfg_q != '0) ? S_DELAY : S_CAPTURE;
            end
         end
         S_DELAY: begin
            s_ready = 1'b1;
            if (abort) begin
               cont_d  = 1'b0;
               state_d = S_IDLE;
            end else if (s_axis.tvalid) begin
               delay_cnt_d = delay_cnt_q - DELAY_ONE;
               if (delay_cnt_q == DELAY_ONE) state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (abort) begin
               // A beat still waiting downstream closes the packet; an empty
               // (or just-draining) register leaves it open for the timeout.
               cont_d = 1'b0;
               if (out_valid_q && !m_axis.tready) begin
                  out_last_d = 1'b1;
                  aborted_d  = 1'b1;
                  state_d    = S_DRAIN;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               s_ready = ~out_valid_q | m_axis.tready;
               if (s_ready && s_axis.tvalid) begin
                  out_valid_d = 1'b1;
                  out_data_d  = s_axis.tdata;
                  out_last_d  = (beat_cnt_q == LEN_ONE);
                  beat_cnt_d  = beat_cnt_q - LEN_ONE;
                  if (beat_cnt_q == LEN_ONE) state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (abort) cont_d = 1'b0;
            if (m_hs) begin
               done       = ~aborted_q;
               out_last_d = 1'b0;
               aborted_d  = 1'b0;
               state_d    = (cont_q && !abort && !aborted_q) ? S_ARMED : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_cfg_q   <= '0;
         delay_cfg_q <= '0;
         cont_q      <= 1'b0;
         beat_cnt_q  <= '0;
         delay_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_cfg_q   <= len_cfg_d;
         delay_cfg_q <= delay_cfg_d;
         cont_q      <= cont_d;
         beat_cnt_q  <= beat_cnt_d;
         delay_cnt_q <= delay_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         aborted_q   <= aborted_d;
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tdata  = out_data_q;
   assign m_axis.tlast  = out_last_q;
   assign busy          = (state_q != S_IDLE);

`ifdef CAPTURE_STALL_CNT_EN
   logic [STALL_WIDTH-1:0] stall_q, stall_d;
   logic                   arm_accept;

   assign arm_accept = (state_q == S_IDLE) && arm && !abort && (cfg_length != '0);

   always_comb begin
      stall_d = stall_q;
      if (arm_accept)
         stall_d = '0;
      else if (state_q == S_CAPTURE && s_axis.tvalid && !s_ready && stall_q != '1)
         stall_d = stall_q + STALL_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif
endmodule
